// File: rtl/picobus_decoder.sv
// Address decoder and response mux for the picorv32 native memory bus.
// Registered slave select, per-access timeout and sticky error status.
module picobus_decoder #(
    parameter int                 NSLV      = 4,
    parameter int                 REGION_SH = 28,
    parameter logic [NSLV*16-1:0] SLV_MAP   = 64'h0000_0000_0020_0301,
    parameter int                 TIMEOUT   = 1024,
    parameter logic [31:0]        ERR_RDATA = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_valid,
    output logic               m_ready,
    input  logic [31:0]        m_addr,
    input  logic [31:0]        m_wdata,
    input  logic [3:0]         m_wstrb,
    output logic [31:0]        m_rdata,
    output logic [NSLV-1:0]    s_valid,
    input  logic [NSLV-1:0]    s_ready,
    output logic [31:0]        s_addr,
    output logic [31:0]        s_wdata,
    output logic [3:0]         s_wstrb,
    input  logic [NSLV*32-1:0] s_rdata,
    input  logic               err_clr,
    output logic               err_flag,
    output logic [31:0]        err_addr,
    output logic [7:0]         err_cnt
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   hit_idx;
    logic            hit;
    logic [3:0]      region;
    logic [CW-1:0]   tcnt;
    logic            sel_ready;
    logic            tmo_last;
    logic            enter_err;

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    assign region = m_addr[REGION_SH+3:REGION_SH];

    // Descending scan so the lowest-numbered owner wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (SLV_MAP[16*k + int'(region)]) begin
                hit     = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    assign sel_ready = s_ready[sel];
    assign tmo_last  = (tcnt == CW'(TIMEOUT - 1));
    assign enter_err = (state_nx == ERR) && (state != ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (m_valid) begin
                    state_nx = hit ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (!m_valid || sel_ready) begin
                    state_nx = IDLE;
                end else if (tmo_last) begin
                    state_nx = ERR;
                end
            end
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_valid = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        unique case (state)
            BUSY: begin
                s_valid[sel] = m_valid;
                m_ready      = m_valid & sel_ready;
                m_rdata      = s_rdata[32*sel +: 32];
            end
            ERR: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= '0;
            tcnt <= '0;
        end else begin
            if (state == IDLE && m_valid && hit) begin
                sel <= hit_idx;
            end
            if (state == BUSY && state_nx == BUSY) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end
        end
    end

    // A clear landing together with a new error restarts the log from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (enter_err) begin
            err_flag <= 1'b1;
            if (err_clr) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (!err_flag || err_clr) begin
                err_addr <= m_addr;
            end
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_picobus_decoder.sv
// Bench for picobus_decoder: directed cases plus randomized accesses
// compared against a transaction-level reference model.
module tb_picobus_decoder;

    localparam int          NSLV = 4;
    localparam int          TMO  = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic               clk;
    logic               rst;
    logic               m_valid;
    logic               m_ready;
    logic [31:0]        m_addr;
    logic [31:0]        m_wdata;
    logic [3:0]         m_wstrb;
    logic [31:0]        m_rdata;
    logic [NSLV-1:0]    s_valid;
    logic [NSLV-1:0]    s_ready;
    logic [31:0]        s_addr;
    logic [31:0]        s_wdata;
    logic [3:0]         s_wstrb;
    logic [NSLV*32-1:0] s_rdata;
    logic               err_clr;
    logic               err_flag;
    logic [31:0]        err_addr;
    logic [7:0]         err_cnt;

    picobus_decoder #(
        .NSLV      (NSLV),
        .REGION_SH (28),
        .SLV_MAP   (64'h0000_0000_0020_0301),
        .TIMEOUT   (TMO),
        .ERR_RDATA (ERRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .err_clr  (err_clr),
        .err_flag (err_flag),
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] map_tbl [NSLV] = '{16'h0301, 16'h0020, 16'h0000, 16'h0000};
    logic [31:0] sd [NSLV];

    bit          rf;
    int          rc;
    logic [31:0] ra;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_slave(input logic [31:0] a);
        int          r;
        logic [15:0] m;
        r = int'(a[31:28]);
        for (int k = 0; k < NSLV; k++) begin
            m = map_tbl[k];
            if (m[r]) return k;
        end
        return -1;
    endfunction

    task automatic check_err(input string tag);
        check({tag, ".flag"}, 32'(err_flag), 32'(rf));
        check({tag, ".cnt"},  32'(err_cnt),  32'(rc));
        check({tag, ".addr"}, err_addr, ra);
    endtask

    // lat: slave asserts s_ready on its lat-th s_valid cycle; lat<0 = hung
    task automatic txn(input logic [31:0] a, input logic [3:0] ws,
                       input int lat, input bit clr0, input string tag);
        int          tgt, exp_rdy, exp_sv, first_sv, sv_cnt, rdy_cyc;
        bit          err, bad_sel;
        logic [31:0] exp_d, got_d, wd;
        wd       = $urandom;
        first_sv = -1;
        sv_cnt   = 0;
        rdy_cyc  = -1;
        bad_sel  = 0;
        got_d    = '0;
        for (int k = 0; k < NSLV; k++) begin
            sd[k] = $urandom;
            s_rdata[32*k +: 32] = sd[k];
        end
        tgt = ref_slave(a);
        if (tgt < 0) begin
            err = 1; exp_rdy = 1; exp_sv = 0;
        end else if (lat < 0 || lat >= TMO) begin
            err = 1; exp_rdy = TMO + 1; exp_sv = TMO;
        end else begin
            err = 0; exp_rdy = lat + 1; exp_sv = lat + 1;
        end
        exp_d = err ? ERRD : sd[tgt];
        for (int c = 0; c < TMO + 4; c++) begin
            @(negedge clk);
            m_valid = 1'b1;
            m_addr  = a;
            m_wdata = wd;
            m_wstrb = ws;
            err_clr = clr0 && (c == 0);
            s_ready = '0;
            #1;
            if (c == 0) begin
                check({tag, ".bcast"}, s_addr ^ s_wdata, a ^ wd);
                check({tag, ".wstrb"}, 32'(s_wstrb), 32'(ws));
            end
            if (s_valid != '0) begin
                sv_cnt++;
                if (first_sv < 0) first_sv = c;
                if (tgt < 0 || s_valid != (NSLV'(1) << tgt)) bad_sel = 1;
                else if (sv_cnt - 1 == lat) s_ready[tgt] = 1'b1;
            end
            #1;
            if (m_ready) begin
                rdy_cyc = c;
                got_d   = m_rdata;
                break;
            end
        end
        @(negedge clk);
        m_valid = 1'b0;
        err_clr = 1'b0;
        s_ready = '0;
        #2;
        check({tag, ".ready_pulse"}, 32'(m_ready), 32'd0);
        if (clr0) begin
            rf = 0; rc = 0;
        end
        if (err) begin
            if (!rf) ra = a;
            rf = 1;
            rc = (rc < 255) ? rc + 1 : 255;
        end
        check({tag, ".rdy_cyc"},  32'(rdy_cyc),  32'(exp_rdy));
        check({tag, ".rdata"},    got_d,         exp_d);
        check({tag, ".sv_cnt"},   32'(sv_cnt),   32'(exp_sv));
        check({tag, ".sv_first"}, 32'(first_sv), (tgt < 0) ? 32'hFFFF_FFFF : 32'd1);
        check({tag, ".sel"},      32'(bad_sel),  32'd0);
        check_err(tag);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        rf = 0;
        rc = 0;
        #1;
        check("clr.flag", 32'(err_flag), 32'd0);
        check("clr.cnt",  32'(err_cnt),  32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        rst = 1'b1;
        m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rdata = '0; err_clr = 1'b0;
        rf = 0; rc = 0; ra = '0;
        repeat (3) @(negedge clk);
        check("rst.s_valid", 32'(s_valid), 32'd0);
        check("rst.m_ready", 32'(m_ready), 32'd0);
        check("rst.m_rdata", m_rdata, 32'd0);
        check_err("rst");
        rst = 1'b0;

        txn(32'h0000_0010, 4'h0, 2, 0, "t1_read");
        txn(32'h5000_0004, 4'hF, 1, 0, "t2_write");
        txn(32'h3000_0000, 4'h0, 0, 0, "t3_unmapped");
        txn(32'h5000_0008, 4'hF, -1, 0, "t4_timeout");
        txn(32'h0000_0020, 4'h0, TMO - 1, 0, "t5_lastcyc");
        txn(32'h9000_0000, 4'h0, TMO, 0, "t5_late");
        clear_err();
        txn(32'h7000_0040, 4'h0, 0, 1, "clr_coincide");
        txn(32'hF000_0000, 4'h3, 0, 0, "addr_hold");

        // master abandons the access while BUSY
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h8000_0100;
        @(negedge clk);
        #1;
        check("abort.s_valid_on", 32'(s_valid), 32'd1);
        m_valid = 1'b0;
        #1;
        check("abort.s_valid_off", 32'(s_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("abort.no_ready", 32'(m_ready), 32'd0);
        end
        check_err("abort");
        txn(32'h5000_0000, 4'h0, 0, 0, "after_abort");

        // reset in the middle of an access
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h5000_0010;
        @(negedge clk);
        #1;
        check("mrst.busy", 32'(s_valid), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mrst.s_valid", 32'(s_valid), 32'd0);
        check("mrst.m_ready", 32'(m_ready), 32'd0);
        rf = 0; rc = 0; ra = '0;
        check_err("mrst");
        rst = 1'b0;
        m_valid = 1'b0;
        txn(32'h0000_0004, 4'h1, 3, 0, "after_rst");

        for (int i = 0; i < 150; i++) begin
            a = {4'($urandom_range(0, 15)), 28'($urandom)};
            if ($urandom_range(0, 9) == 0) lat = -1;
            else lat = $urandom_range(0, TMO + 1);
            txn(a, 4'($urandom), lat, ($urandom_range(0, 19) == 0), "rand");
        end

        for (int i = 0; i < 300; i++) begin
            a = {4'($urandom_range(1, 4)), 28'($urandom)};
            txn(a, 4'h0, 0, 0, "sat");
        end
        check("sat.final", 32'(err_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
